// File: rtl/bottle_pkg.sv
// Shared types, constants and the BCD increment helper for the bottle filling controller.
package bottle_pkg;

    localparam int BCD_W          = 4;
    localparam int BCD_MAX_DIGITS = 8;
    localparam int BCD_MAX_W      = BCD_W * BCD_MAX_DIGITS;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        SWAP = 2'd2,
        STOP = 2'd3
    } lane_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

    // Adds one to the lowest 'digits' BCD digits of value, rippling a 9->0 carry upward.
    // Digits above 'digits' are passed through untouched.
    function automatic logic [BCD_MAX_W-1:0] bcd_inc(input logic [BCD_MAX_W-1:0] value,
                                                     input int digits);
        logic [BCD_MAX_W-1:0] res;
        logic                 carry;
        res   = value;
        carry = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if ((i < digits) && carry) begin
                if (value[i*BCD_W +: BCD_W] == 4'd9) begin
                    res[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    res[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bottle_fill_ctrl_bcd_counter.sv
// Multi-digit BCD counter with synchronous clear and a "this increment reaches the limit" flag.
module bcd_counter
    import bottle_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      clr,
    input  logic                      inc,
    input  logic [BCD_W*DIGITS-1:0]   limit,
    output logic [BCD_W*DIGITS-1:0]   value,
    output logic                      eq
);

    localparam int W = BCD_W * DIGITS;

    logic [BCD_MAX_W-1:0] value_ext;
    logic [BCD_MAX_W-1:0] limit_ext;
    logic [BCD_MAX_W-1:0] next_ext;

    // Next BCD value and limit detection; eq is asserted only in the cycle whose
    // increment lands exactly on the limit, so the caller can act on the same edge.
    always_comb begin
        value_ext = BCD_MAX_W'(value);
        limit_ext = BCD_MAX_W'(limit);
        next_ext  = bcd_inc(value_ext, DIGITS);
        eq        = inc && (next_ext == limit_ext);
    end

    // Count register; clear wins over increment.
    always_ff @(posedge CLK) begin
        if (RST) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= W'(next_ext);
        end
    end

endmodule

// File: rtl/bottle_fill_ctrl.sv
// Multi-lane pill bottling controller: per-lane BCD pill counting, fixed-priority commit
// of full bottles into a shared BCD bottle counter, auto-swap or acknowledged changeover.
//
//   run state | meaning
//   IDLE      | after reset, waiting for a start with nonzero limits
//   RUN       | lanes filling and committing bottles
//   DONE      | bottle total reached, all lanes stopped
//
//   lane state | meaning
//   FILL       | counting pills into the current bottle
//   FULL       | bottle at limit, requesting a commit
//   SWAP       | committed in manual mode, waiting for bot_ack
//   STOP       | run not active (reset, idle or done)
module bottle_fill_ctrl
    import bottle_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int PILL_DIGITS = 2,
    parameter int BOT_DIGITS  = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  start,
    input  logic                                  pause,
    input  logic                                  conti,
    input  logic [CHANNELS-1:0]                   bot_ack,
    input  logic [CHANNELS-1:0]                   pill,
    input  logic [BCD_W*PILL_DIGITS-1:0]          pill_max,
    input  logic [BCD_W*BOT_DIGITS-1:0]           bot_max,
    output logic [CHANNELS*BCD_W*PILL_DIGITS-1:0] pill_cnt,
    output logic [BCD_W*BOT_DIGITS-1:0]           bot_cnt,
    output logic [CHANNELS-1:0]                   bot_done,
    output logic                                  all_full,
    output logic                                  busy
);

    localparam int PW = BCD_W * PILL_DIGITS;
    localparam int BW = BCD_W * BOT_DIGITS;

    run_state_t          run_q;
    run_state_t          run_d;
    lane_state_t         lane_q [CHANNELS];
    lane_state_t         lane_d [CHANNELS];

    logic [PW-1:0]       pill_max_q;
    logic [BW-1:0]       bot_max_q;

    logic                start_ok;
    logic                gnt_any;
    logic                bot_hit;
    logic                found;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] gnt;
    logic [CHANNELS-1:0] lane_inc;
    logic [CHANNELS-1:0] lane_clr;
    logic [CHANNELS-1:0] lane_hit;

    // A start is honoured only outside RUN and only with both limits nonzero.
    assign start_ok = start && (run_q != RUN) && (pill_max != '0) && (bot_max != '0);

    // Per-lane request/increment/clear terms and the lowest-index-first commit grant.
    always_comb begin
        req      = '0;
        gnt      = '0;
        lane_inc = '0;
        lane_clr = '0;
        found    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            req[i]      = (lane_q[i] == FULL);
            lane_inc[i] = (lane_q[i] == FILL) && pill[i] && !pause;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            lane_clr[i] = start_ok
                        || (gnt[i] && conti)
                        || ((lane_q[i] == SWAP) && bot_ack[i]);
        end
    end

    assign gnt_any = |req;

    // Next-state logic for the run FSM and every lane; the final commit forces all lanes to STOP.
    always_comb begin
        run_d = run_q;
        for (int i = 0; i < CHANNELS; i++) begin
            lane_d[i] = lane_q[i];
        end
        case (run_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    run_d = RUN;
                end
            end
            RUN: begin
                if (bot_hit) begin
                    run_d = DONE;
                end
            end
            default: run_d = IDLE;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (start_ok) begin
                lane_d[i] = FILL;
            end else if (run_q == RUN) begin
                if (bot_hit) begin
                    lane_d[i] = STOP;
                end else begin
                    case (lane_q[i])
                        FILL: if (lane_hit[i]) lane_d[i] = FULL;
                        FULL: if (gnt[i])      lane_d[i] = conti ? FILL : SWAP;
                        SWAP: if (bot_ack[i])  lane_d[i] = FILL;
                        default: lane_d[i] = lane_q[i];
                    endcase
                end
            end
        end
    end

    // State registers, latched limits and the registered commit pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            run_q      <= IDLE;
            pill_max_q <= '0;
            bot_max_q  <= '0;
            bot_done   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                lane_q[i] <= STOP;
            end
        end else begin
            run_q    <= run_d;
            bot_done <= gnt;
            if (start_ok) begin
                pill_max_q <= pill_max;
                bot_max_q  <= bot_max;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign busy     = (run_q == RUN);
    assign all_full = (run_q == DONE);

    // One pill counter per lane; lane_hit flags the pill that fills the bottle.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        bcd_counter #(
            .DIGITS (PILL_DIGITS)
        ) u_pill_cnt (
            .CLK   (CLK),
            .RST   (RST),
            .clr   (lane_clr[g]),
            .inc   (lane_inc[g]),
            .limit (pill_max_q),
            .value (pill_cnt[g*PW +: PW]),
            .eq    (lane_hit[g])
        );
    end

    // Shared bottle counter; bot_hit marks the commit that completes the run.
    bcd_counter #(
        .DIGITS (BOT_DIGITS)
    ) u_bot_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (start_ok),
        .inc   (gnt_any),
        .limit (bot_max_q),
        .value (bot_cnt),
        .eq    (bot_hit)
    );

endmodule
